// File: rtl/plane_draw_datapath.sv
// Plane drawing datapath: walks the visible planes and emits one VGA pixel write
// per cycle for each plane sprite, or sweeps the whole screen for a clear.
module plane_draw_datapath #(
  parameter int          SPRITE_W     = 4,
  parameter int          SPRITE_H     = 4,
  parameter int          SCREEN_W     = 160,
  parameter int          SCREEN_H     = 120,
  parameter logic [2:0]  PLANE_COLOUR = 3'b111,
  parameter logic [2:0]  BG_COLOUR    = 3'b000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [79:0] x_bus,
  input  logic [79:0] y_bus,
  input  logic [9:0]  vis,
  input  logic [1:0]  op,
  input  logic        load_coord,
  input  logic        enable_datapath,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_DRAW,
    S_CLEAR,
    S_DONE
  } state_t;

  localparam logic [2:0] DX_LAST    = 3'(SPRITE_W - 1);
  localparam logic [2:0] DY_LAST    = 3'(SPRITE_H - 1);
  localparam logic [7:0] CX_LAST    = 8'(SCREEN_W - 1);
  localparam logic [6:0] CY_LAST    = 7'(SCREEN_H - 1);
  localparam logic [8:0] X_LIMIT    = 9'(SCREEN_W);
  localparam logic [8:0] Y_LIMIT    = 9'(SCREEN_H);
  localparam logic [3:0] LAST_PLANE = 4'd9;

  state_t      state_q, state_d;
  // Sixteen entries so the 4-bit plane index addresses the array exactly.
  logic [7:0]  shadow_x_q [16];
  logic [7:0]  shadow_x_d [16];
  logic [7:0]  shadow_y_q [16];
  logic [7:0]  shadow_y_d [16];
  logic [15:0] vis_q, vis_d;
  logic [1:0]  op_q, op_d;
  logic [3:0]  p_q, p_d;
  logic [2:0]  dx_q, dx_d;
  logic [2:0]  dy_q, dy_d;
  logic [7:0]  cx_q, cx_d;
  logic [6:0]  cy_q, cy_d;
  logic [7:0]  vga_x_q, vga_x_d;
  logic [6:0]  vga_y_q, vga_y_d;
  logic [2:0]  colour_q, colour_d;
  logic        plot_q, plot_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        start;
  logic [8:0]  pix_x;
  logic [8:0]  pix_y;
  logic [2:0]  draw_colour;

  always_comb begin
    state_d    = state_q;
    shadow_x_d = shadow_x_q;
    shadow_y_d = shadow_y_q;
    vis_d      = vis_q;
    op_d       = op_q;
    p_d        = p_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    vga_x_d    = vga_x_q;
    vga_y_d    = vga_y_q;
    colour_d   = colour_q;
    plot_d     = 1'b0;

    start       = (state_q == S_IDLE) && enable_datapath;
    pix_x       = {1'b0, shadow_x_q[p_q]} + {6'd0, dx_q};
    pix_y       = {1'b0, shadow_y_q[p_q]} + {6'd0, dy_q};
    draw_colour = (op_q == 2'b01) ? PLANE_COLOUR : BG_COLOUR;

    case (state_q)
      S_IDLE: begin
        if (load_coord) begin
          for (int i = 0; i < 10; i++) begin
            shadow_x_d[i] = x_bus[8*i +: 8];
            shadow_y_d[i] = y_bus[8*i +: 8];
          end
        end
        if (enable_datapath) begin
          op_d  = op;
          vis_d = {6'd0, vis};
          p_d   = 4'd0;
          cx_d  = 8'd0;
          cy_d  = 7'd0;
          case (op)
            2'b10:   state_d = S_CLEAR;
            2'b11:   state_d = S_DONE;
            default: state_d = S_SCAN;
          endcase
        end
      end

      S_SCAN: begin
        if (vis_q[p_q]) begin
          dx_d    = 3'd0;
          dy_d    = 3'd0;
          state_d = S_DRAW;
        end else if (p_q == LAST_PLANE) begin
          state_d = S_DONE;
        end else begin
          p_d = p_q + 4'd1;
        end
      end

      // Off-screen pixels are suppressed but still consume their cycle.
      S_DRAW: begin
        plot_d   = (pix_x < X_LIMIT) && (pix_y < Y_LIMIT);
        vga_x_d  = pix_x[7:0];
        vga_y_d  = pix_y[6:0];
        colour_d = draw_colour;
        if (dx_q == DX_LAST) begin
          dx_d = 3'd0;
          if (dy_q == DY_LAST) begin
            dy_d = 3'd0;
            if (p_q == LAST_PLANE) begin
              state_d = S_DONE;
            end else begin
              p_d     = p_q + 4'd1;
              state_d = S_SCAN;
            end
          end else begin
            dy_d = dy_q + 3'd1;
          end
        end else begin
          dx_d = dx_q + 3'd1;
        end
      end

      S_CLEAR: begin
        plot_d   = 1'b1;
        vga_x_d  = cx_q;
        vga_y_d  = cy_q;
        colour_d = BG_COLOUR;
        if (cx_q == CX_LAST) begin
          cx_d = 8'd0;
          if (cy_q == CY_LAST) begin
            state_d = S_DONE;
          end else begin
            cy_d = cy_q + 7'd1;
          end
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // A no-op pass still shows one busy cycle before its done pulse.
    busy_d = (state_d inside {S_SCAN, S_DRAW, S_CLEAR}) || (start && (op == 2'b11));
    done_d = ((state_d == S_DONE) && (state_q != S_IDLE)) ||
             ((state_q == S_DONE) && !done_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      shadow_x_q <= '{default: '0};
      shadow_y_q <= '{default: '0};
      vis_q      <= '0;
      op_q       <= '0;
      p_q        <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      vga_x_q    <= '0;
      vga_y_q    <= '0;
      colour_q   <= '0;
      plot_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_x_q <= shadow_x_d;
      shadow_y_q <= shadow_y_d;
      vis_q      <= vis_d;
      op_q       <= op_d;
      p_q        <= p_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      vga_x_q    <= vga_x_d;
      vga_y_q    <= vga_y_d;
      colour_q   <= colour_d;
      plot_q     <= plot_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign vga_x  = vga_x_q;
  assign vga_y  = vga_y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_plane_draw_datapath.sv
// Scoreboard bench for plane_draw_datapath: stimulus pushes expected pixels,
// a negedge monitor pops and compares every plotted pixel.
module tb_plane_draw_datapath;

  typedef logic [17:0] pix_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [79:0] x_bus;
  logic [79:0] y_bus;
  logic [9:0]  vis;
  logic [1:0]  op;
  logic        load_coord;
  logic        enable_datapath;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        done;

  pix_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  bit   monitor_on = 1'b1;
  int   busy_cnt = 0;
  int   done_cnt = 0;
  int   plot_cnt = 0;
  int   b0, d0, p0;

  plane_draw_datapath dut (
    .clk             (clk),
    .reset           (reset),
    .x_bus           (x_bus),
    .y_bus           (y_bus),
    .vis             (vis),
    .op              (op),
    .load_coord      (load_coord),
    .enable_datapath (enable_datapath),
    .vga_x           (vga_x),
    .vga_y           (vga_y),
    .colour          (colour),
    .plot            (plot),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: counts activity and checks every plotted pixel against the scoreboard.
  always @(negedge clk) begin
    pix_t e;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (plot) plot_cnt++;
    if (monitor_on && plot) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_plot: got x=%0d y=%0d c=%0d expected no plot",
                 vga_x, vga_y, colour);
      end else begin
        e = exp_q.pop_front();
        checkOutput("pixel", int'({vga_x, vga_y, colour}), int'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic ld, input logic en, input logic [79:0] xb,
                               input logic [79:0] yb, input logic [9:0] v, input logic [1:0] o);
    load_coord      = ld;
    enable_datapath = en;
    x_bus           = xb;
    y_bus           = yb;
    vis             = v;
    op              = o;
    tick();
    load_coord      = 1'b0;
    enable_datapath = 1'b0;
  endtask

  task automatic snap();
    b0 = busy_cnt;
    d0 = done_cnt;
    p0 = plot_cnt;
  endtask

  task automatic push_pix(input int x, input int y, input logic [2:0] c);
    logic [7:0] px;
    logic [6:0] py;
    px = 8'(x);
    py = 7'(y);
    exp_q.push_back({px, py, c});
  endtask

  task automatic push_rect(input int x0, input int y0, input logic [2:0] c);
    for (int dy = 0; dy < 4; dy++)
      for (int dx = 0; dx < 4; dx++)
        push_pix(x0 + dx, y0 + dy, c);
  endtask

  task automatic finish_pass(input string name, input int exp_busy, input int exp_plots,
                             input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: got no done expected done within %0d cycles", name, budget);
    end
    repeat (4) tick();
    checkOutput({name, "_busy"}, busy_cnt - b0, exp_busy);
    checkOutput({name, "_done"}, done_cnt - d0, 1);
    checkOutput({name, "_plots"}, plot_cnt - p0, exp_plots);
    checkOutput({name, "_sb_left"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    checkOutput({name, "_x"}, int'(vga_x), 0);
    checkOutput({name, "_y"}, int'(vga_y), 0);
    checkOutput({name, "_colour"}, int'(colour), 0);
    checkOutput({name, "_plot"}, int'(plot), 0);
    checkOutput({name, "_busy"}, int'(busy), 0);
    checkOutput({name, "_done"}, int'(done), 0);
  endtask

  initial begin
    logic [79:0] xb;
    logic [79:0] yb;

    reset = 1'b1;
    load_coord = 1'b0;
    enable_datapath = 1'b0;
    x_bus = '0;
    y_bus = '0;
    vis = '0;
    op = 2'b11;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    $display("[TB] single plane draw at (10,20)");
    xb = '0; yb = '0;
    xb[7:0] = 8'd10; yb[7:0] = 8'd20;
    push_rect(10, 20, 3'b111);
    snap();
    applyStimulus(1'b1, 1'b1, xb, yb, 10'b1, 2'b01);
    finish_pass("draw1", 26, 16, 100);

    $display("[TB] no visible planes");
    snap();
    applyStimulus(1'b0, 1'b1, '0, '0, 10'b0, 2'b01);
    finish_pass("novis", 10, 0, 100);

    $display("[TB] plane 9 erase at screen corner");
    xb = '0; yb = '0;
    xb[7:0] = 8'd10;    yb[7:0] = 8'd20;
    xb[79:72] = 8'd158; yb[79:72] = 8'd118;
    push_pix(158, 118, 3'b000);
    push_pix(159, 118, 3'b000);
    push_pix(158, 119, 3'b000);
    push_pix(159, 119, 3'b000);
    snap();
    applyStimulus(1'b1, 1'b1, xb, yb, 10'b10_0000_0000, 2'b00);
    finish_pass("corner", 26, 4, 100);

    $display("[TB] no-op pass");
    snap();
    applyStimulus(1'b0, 1'b1, '0, '0, 10'h3ff, 2'b11);
    finish_pass("nop", 1, 0, 20);

    $display("[TB] full screen clear");
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        push_pix(x, y, 3'b000);
    snap();
    applyStimulus(1'b0, 1'b1, '0, '0, 10'h0, 2'b10);
    finish_pass("clear", 19200, 19200, 20000);

    $display("[TB] load and enable ignored while busy");
    push_rect(10, 20, 3'b111);
    snap();
    applyStimulus(1'b0, 1'b1, '0, '0, 10'b1, 2'b01);
    repeat (4) tick();
    xb = '0; yb = '0;
    xb[7:0] = 8'd50; yb[7:0] = 8'd60;
    applyStimulus(1'b1, 1'b1, xb, yb, 10'h3ff, 2'b10);
    finish_pass("busyign", 26, 16, 100);

    $display("[TB] following pass keeps old coords");
    push_rect(10, 20, 3'b111);
    snap();
    applyStimulus(1'b0, 1'b1, '0, '0, 10'b1, 2'b01);
    finish_pass("oldcoord", 26, 16, 100);

    $display("[TB] reset during draw");
    monitor_on = 1'b0;
    applyStimulus(1'b0, 1'b1, '0, '0, 10'b1, 2'b01);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check_reset_outputs("midreset");
    reset = 1'b0;
    snap();
    repeat (40) tick();
    checkOutput("midreset_no_done", done_cnt - d0, 0);
    checkOutput("midreset_no_plot", plot_cnt - p0, 0);
    checkOutput("midreset_no_busy", busy_cnt - b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
